// File: rtl/wb_commit_if.sv
// wb_commit_if: commit beat, register read ports, store write channel and status; slave = unit, master = producer/memory
interface wb_commit_if #(
  parameter int XLEN = 64,
  parameter int AW = 5,
  parameter int SQ_DEPTH = 4
);
  logic in_valid, in_ready, rd_wen, res_sel, st_en, ebreak;
  logic [AW-1:0] rd_addr, rs1_addr, rs2_addr;
  logic [XLEN-1:0] ex_res, mem_res, st_addr, rs1_data, rs2_data;
  logic [XLEN/8-1:0] st_wmask, mem_wmask;
  logic [2:0] ext_mode;
  logic mem_wvalid, mem_wready, halted;
  logic [XLEN-1:0] mem_waddr, mem_wdata;
  logic [$clog2(SQ_DEPTH):0] sq_count;
  modport slave (
    input in_valid, rd_wen, rd_addr, res_sel, ex_res, mem_res, ext_mode, st_en, st_addr, st_wmask, ebreak,
    input rs1_addr, rs2_addr, mem_wready,
    output in_ready, rs1_data, rs2_data, mem_wvalid, mem_waddr, mem_wdata, mem_wmask, halted, sq_count
  );
  modport master (
    output in_valid, rd_wen, rd_addr, res_sel, ex_res, mem_res, ext_mode, st_en, st_addr, st_wmask, ebreak,
    output rs1_addr, rs2_addr, mem_wready,
    input in_ready, rs1_data, rs2_data, mem_wvalid, mem_waddr, mem_wdata, mem_wmask, halted, sq_count
  );
endinterface

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback/commit stage (clk, rst, bus slave) with register file, bypassed read ports, store queue and ebreak drain/halt
module wb_commit_unit #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int SQ_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  wb_commit_if.slave bus
);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = XLEN / 8;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  state_t state;
  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] sq_addr [SQ_DEPTH];
  logic [XLEN-1:0] sq_data [SQ_DEPTH];
  logic [MW-1:0] sq_mask [SQ_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [XLEN-1:0] res, ext;
  logic acc, wr, push, pop;
  assign bus.in_ready = state == RUN && count < CW'(SQ_DEPTH) && !rst;
  assign acc = bus.in_valid && bus.in_ready;
  assign wr = acc && bus.rd_wen && bus.rd_addr != '0 && !bus.st_en && !bus.ebreak;
  assign push = acc && bus.st_en && !bus.ebreak;
  assign bus.mem_wvalid = count != '0 && !rst;
  assign pop = bus.mem_wvalid && bus.mem_wready;
  assign bus.sq_count = rst ? '0 : count;
  assign bus.halted = state == HALT && !rst;
  assign bus.mem_waddr = sq_addr[head];
  assign bus.mem_wdata = sq_data[head];
  assign bus.mem_wmask = sq_mask[head];
  assign res = bus.res_sel ? bus.mem_res : bus.ex_res;
  always_comb
    ext = bus.ext_mode == 3'd1 ? {{(XLEN-32){res[31]}}, res[31:0]}
        : bus.ext_mode == 3'd2 ? {{(XLEN-32){1'b0}}, res[31:0]}
        : bus.ext_mode == 3'd3 ? {{(XLEN-16){res[15]}}, res[15:0]}
        : bus.ext_mode == 3'd4 ? {{(XLEN-16){1'b0}}, res[15:0]}
        : bus.ext_mode == 3'd5 ? {{(XLEN-8){res[7]}}, res[7:0]}
        : bus.ext_mode == 3'd6 ? {{(XLEN-8){1'b0}}, res[7:0]}
        : res;
  // a write landing this cycle is forwarded to readers of the same register
  assign bus.rs1_data = bus.rs1_addr == '0 ? '0 : (wr && bus.rd_addr == bus.rs1_addr) ? ext : regs[bus.rs1_addr];
  assign bus.rs2_data = bus.rs2_addr == '0 ? '0 : (wr && bus.rd_addr == bus.rs2_addr) ? ext : regs[bus.rs2_addr];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= RUN;
    end else begin
      if (wr) regs[bus.rd_addr] <= ext;
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      case (state)
        RUN: if (acc && bus.ebreak) state <= DRAIN;
        DRAIN: if (count == '0) state <= HALT;
        default: state <= HALT;
      endcase
    end
  always_ff @(posedge clk)
    if (push) begin
      sq_addr[tail] <= bus.st_addr;
      sq_data[tail] <= res;
      sq_mask[tail] <= bus.st_wmask;
    end
endmodule
